proj_arbiter: RTL and testbench
===============================

Name: proj_arbiter

Overview:
- Shares one projection unit (64-bit A/B operands, start/done handshake) between NREQ requesters in the 2x2 MIMO ZF detector, e.g. the Gram-Schmidt column stages.
- Round-robin arbitration; only one operation is outstanding at a time.
- Latches the winner's operands, pulses the unit's start, waits for done with a timeout, then returns the result to the winner only.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 64, operand/result width.
- TIMEOUT, 255, max cycles in WAIT before abort (>=1).
- CW, 8, timeout counter width; 2^CW-1 >= TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- req_a  in  NREQ*W  operand A; requester i at [i*W +: W].
- req_b  in  NREQ*W  operand B, same packing.
- gnt  out  NREQ  one-hot grant, held from ISSUE through DELIVER.
- rsp_valid  out  NREQ  one-cycle pulse to the winner in DELIVER.
- rsp_data  out  W  result; valid while rsp_valid!=0.
- rsp_err  out  1  high with rsp_valid when the operation timed out.
- busy  out  1  high in any state other than IDLE.
- prj_a  out  W  latched operand A to the unit.
- prj_b  out  W  latched operand B to the unit.
- prj_start  out  1  one-cycle start pulse.
- prj_result  in  W  unit result.
- prj_done  in  1  unit done level.

Behaviour:
- Reset, sampled at posedge: state=IDLE; gnt, rsp_valid, rsp_err, busy, prj_start = 0; rsp_data, prj_a, prj_b = 0; rr_ptr=0; timeout counter=0.
- Reset asserted mid-operation aborts immediately. No response is produced, and the unit's late prj_done is ignored (controller is in IDLE).
- States IDLE -> ISSUE -> WAIT -> DELIVER -> IDLE.
- IDLE:
  - If req!=0, pick the winner: first set bit of req searching from rr_ptr upward, wrapping NREQ-1 -> 0.
  - Latch the winner's req_a/req_b into prj_a/prj_b, set gnt, go to ISSUE.
  - If req==0, stay in IDLE.
- ISSUE: prj_start=1 for exactly this cycle; clear the counter; go to WAIT.
- WAIT:
  - prj_start=0; increment the counter each cycle.
  - First cycle with prj_done=1: capture prj_result into rsp_data, rsp_err=0, go to DELIVER.
  - Else, when the counter == TIMEOUT-1: rsp_data=0, rsp_err=1, go to DELIVER.
  - If done and timeout coincide, done wins (rsp_err=0).
- DELIVER:
  - rsp_valid = gnt for one cycle; rsp_data and rsp_err are stable this cycle.
  - rr_ptr = winner+1 mod NREQ; then gnt=0 and state=IDLE.
- Latency, no timeout: req rises at cycle t (IDLE) -> gnt from t+1 -> prj_start at t+1 -> done at cycle d -> rsp_valid at d+1.
  - Minimum idle-to-idle time is 4 cycles.
- prj_done is ignored outside WAIT. A done level still high from the previous op does not complete the next op early: done is qualified only after ISSUE.
- Requester rules:
  - A requester must hold req until it sees its rsp_valid.
  - If req drops after grant, the op still completes and rsp_valid is still pulsed.
  - Operand changes after the grant cycle have no effect (operands are latched).
- Fairness: a requester holding req continuously is served within NREQ grants.
- A requester that re-requests immediately after its response is granted only if no other req bit is set ahead of it in round-robin order.
- prj_a/prj_b hold their value until the next grant.
- The unit requires its operands stable from prj_start to done; latching guarantees this.

Test Plan:
- Single request: req=4'b0010, req_a[1]=req_b[1]=64'h863D01EB09990733, unit model done 3 cycles after start returning 64'h0123456789ABCDEF.
  - gnt=0010 from cycle t+1; prj_start pulse at t+1; rsp_valid=0010 with rsp_data=64'h0123456789ABCDEF at done+1; rsp_err=0.
- Round-robin: req=4'b1111 held, rr_ptr=0.
  - Grant order 0,1,2,3,0; each rsp_valid only on the granted bit.
  - prj_a matches the granted requester's operand every time.
- Timeout: TIMEOUT=8, unit never asserts done.
  - rsp_valid at the winner 8 cycles after ISSUE; rsp_err=1, rsp_data=0; next request served normally.
- Stale done: unit holds prj_done=1 for 3 extra cycles after the first op; second requester already pending.
  - Second op completes only on a done seen in its own WAIT. With prj_done held high through its WAIT, it completes on the first WAIT cycle and returns prj_result from that cycle.
- Reset mid-WAIT: assert reset for 1 cycle in WAIT, then the unit asserts done.
  - All outputs 0, state IDLE, no rsp_valid, rr_ptr=0; a fresh req=4'b0100 is served with the correct result.
- Req drop and operand change: req[2] drops and req_a[2] changes to 64'h0 the cycle after grant.
  - prj_a keeps the original value; rsp_valid[2] is still pulsed with the unit's result.

Source files
------------

// File: rtl/proj_arbiter.sv
// Round-robin arbiter sharing one start/done projection unit between NREQ requesters.
// One operation in flight; operands latched at grant, result returned only to the winner.
module proj_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = 64,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [W-1:0]        rsp_data,
    output logic                rsp_err,
    output logic                busy,
    output logic [W-1:0]        prj_a,
    output logic [W-1:0]        prj_b,
    output logic                prj_start,
    input  logic [W-1:0]        prj_result,
    input  logic                prj_done
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DELIVER
    } state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   win;
    logic [PW-1:0]   pick;
    logic [PW:0]     sum;
    logic            found;
    logic [NREQ-1:0] pick_oh;
    logic [W-1:0]    pick_a;
    logic [W-1:0]    pick_b;
    logic [CW-1:0]   cnt;
    logic            timed_out;

    // Search req starting at rr_ptr, wrapping NREQ-1 -> 0.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ))
                sum = sum - (PW+1)'(NREQ);
            if (!found && req[sum[PW-1:0]]) begin
                found = 1'b1;
                pick  = sum[PW-1:0];
            end
        end
    end

    always_comb begin
        pick_oh = '0;
        pick_a  = '0;
        pick_b  = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (pick == PW'(j)) begin
                pick_oh[j] = 1'b1;
                pick_a     = req_a[j*W +: W];
                pick_b     = req_b[j*W +: W];
            end
        end
    end

    // cnt is cleared at grant and counts ISSUE as the first elapsed cycle, so the
    // abort lands TIMEOUT cycles after ISSUE.
    assign timed_out = (cnt >= CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        prj_start = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (found)
                    state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                prj_start = 1'b1;
                state_nx  = S_WAIT;
            end
            S_WAIT: begin
                if (prj_done || timed_out)
                    state_nx = S_DELIVER;
            end
            S_DELIVER: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            prj_a     <= '0;
            prj_b     <= '0;
            rr_ptr    <= '0;
            win       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        win   <= pick;
                        gnt   <= pick_oh;
                        prj_a <= pick_a;
                        prj_b <= pick_b;
                        cnt   <= '0;
                    end
                end
                S_ISSUE: cnt <= cnt + CW'(1);
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (prj_done) begin
                        rsp_data  <= prj_result;
                        rsp_err   <= 1'b0;
                        rsp_valid <= gnt;
                    end else if (timed_out) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= gnt;
                    end
                end
                S_DELIVER: begin
                    rsp_valid <= '0;
                    gnt       <= '0;
                    rr_ptr    <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_proj_arbiter.sv
// Self-checking bench for proj_arbiter: unit model plus response scoreboard,
// one task per scenario.
module tb_proj_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NREQ-1:0]  req = '0;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  rsp_valid;
    logic [W-1:0]     rsp_data;
    logic             rsp_err;
    logic             busy;
    logic [W-1:0]     prj_a;
    logic [W-1:0]     prj_b;
    logic             prj_start;
    logic [W-1:0]     prj_result = '0;
    logic             prj_done = 1'b0;

    always #5 clk = ~clk;

    proj_arbiter #(.NREQ(4), .W(64), .TIMEOUT(8), .CW(8)) dut (
        .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .prj_a(prj_a), .prj_b(prj_b), .prj_start(prj_start),
        .prj_result(prj_result), .prj_done(prj_done)
    );

    typedef struct {
        int          idx;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [63:0] unit_f(input logic [63:0] a, input logic [63:0] b);
        return {a[31:0], a[63:32]} ^ (b + 64'h9E3779B97F4A7C15);
    endfunction

    function automatic exp_t mk(input int idx, input logic [63:0] data, input logic err);
        exp_t e;
        e.idx = idx; e.data = data; e.err = err;
        return e;
    endfunction

    // Projection unit model: done unit_delay cycles after start, held unit_stale extra cycles.
    int          unit_delay   = 3;
    bit          unit_hang    = 1'b0;
    int          unit_stale   = 0;
    bit          use_fixed    = 1'b0;
    logic [63:0] fixed_result = '0;
    int          cd = 0;
    int          hold_left = 0;

    always @(negedge clk) begin
        prj_result = use_fixed ? fixed_result : unit_f(prj_a, prj_b);
        if (prj_done) begin
            if (hold_left > 0) hold_left--;
            else prj_done = 1'b0;
        end
        if (prj_start) cd = unit_delay;
        else if (cd > 0) begin
            cd--;
            if (cd == 0 && !unit_hang) begin
                prj_done  = 1'b1;
                hold_left = unit_stale;
            end
        end
    end

    // Scoreboard: every response is popped and compared against the queued expectation.
    always @(negedge clk) begin
        if (!reset && rsp_valid !== '0) begin
            exp_t e;
            logic [3:0] oh;
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL rsp_unexpected: rsp_valid=%b with empty scoreboard", rsp_valid);
            end else begin
                e  = sb.pop_front();
                oh = 4'b0001 << e.idx;
                if (rsp_valid !== oh || rsp_data !== e.data || rsp_err !== e.err)
                    $display("FAIL rsp_match: got valid=%b data=%h err=%b, want valid=%b data=%h err=%b",
                             rsp_valid, rsp_data, rsp_err, oh, e.data, e.err);
                else
                    n_pass++;
            end
        end
    end

    // kind 0: gnt != 0, kind 1: rsp_valid != 0; n = negedges waited.
    task automatic wait_for(input int kind, input int maxc, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 1; i <= maxc && !ok; i++) begin
            @(negedge clk);
            if ((kind == 0 && gnt !== '0) || (kind == 1 && rsp_valid !== '0)) begin
                ok = 1'b1;
                n  = i;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({gnt, rsp_valid, rsp_err, busy, prj_start} !== '0)
            $display("FAIL reset_ctrl: gnt=%b rsp_valid=%b err=%b busy=%b start=%b, want all 0",
                     gnt, rsp_valid, rsp_err, busy, prj_start);
        else n_pass++;
        n_checks++;
        if ({rsp_data, prj_a, prj_b} !== '0)
            $display("FAIL reset_data: rsp_data=%h prj_a=%h prj_b=%h, want 0", rsp_data, prj_a, prj_b);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit ok; int n;
        logic [63:0] v = 64'h863D01EB09990733;
        use_fixed    = 1'b1;
        fixed_result = 64'h0123456789ABCDEF;
        req_a[1*W +: W] = v;
        req_b[1*W +: W] = v;
        sb.push_back(mk(1, 64'h0123456789ABCDEF, 1'b0));
        req = 4'b0010;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0010 || prj_start !== 1'b1 || busy !== 1'b1)
            $display("FAIL single_grant: gnt=%b start=%b busy=%b, want 0010 1 1", gnt, prj_start, busy);
        else n_pass++;
        n_checks++;
        if (prj_a !== v || prj_b !== v)
            $display("FAIL single_operands: prj_a=%h prj_b=%h, want %h", prj_a, prj_b, v);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (prj_start !== 1'b0 || gnt !== 4'b0010)
            $display("FAIL single_start_pulse: start=%b gnt=%b, want 0 0010", prj_start, gnt);
        else n_pass++;
        wait_for(1, 20, ok, n);
        n_checks++;
        if (!ok || n != 3)
            $display("FAIL single_latency: ok=%0d cycles=%0d, want 1 3", ok, n);
        else n_pass++;
        req = '0;
        @(negedge clk);
        n_checks++;
        if (gnt !== '0 || busy !== 1'b0 || rsp_valid !== '0)
            $display("FAIL single_idle: gnt=%b busy=%b rsp_valid=%b, want 0", gnt, busy, rsp_valid);
        else n_pass++;
        use_fixed = 1'b0;
    endtask

    task automatic test_round_robin();
        bit ok; int n;
        logic [63:0] a[4];
        logic [63:0] b[4];
        logic [3:0]  want;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            a[i] = {$urandom, $urandom};
            b[i] = {$urandom, $urandom};
            req_a[i*W +: W] = a[i];
            req_b[i*W +: W] = b[i];
        end
        for (int k = 0; k < 5; k++) sb.push_back(mk(k % 4, unit_f(a[k % 4], b[k % 4]), 1'b0));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            want = 4'b0001 << (k % 4);
            wait_for(0, 20, ok, n);
            n_checks++;
            if (!ok || gnt !== want)
                $display("FAIL rr_gnt: step %0d ok=%0d gnt=%b, want %b", k, ok, gnt, want);
            else n_pass++;
            n_checks++;
            if (prj_a !== a[k % 4])
                $display("FAIL rr_prj_a: step %0d prj_a=%h, want %h", k, prj_a, a[k % 4]);
            else n_pass++;
            wait_for(1, 30, ok, n);
            n_checks++;
            if (!ok) $display("FAIL rr_rsp: step %0d no response, want one", k);
            else n_pass++;
            if (k == 4) req = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        bit ok; int n;
        logic [63:0] x = 64'hCAFEF00D12345678;
        unit_hang = 1'b1;
        req_a[3*W +: W] = x;
        req_b[3*W +: W] = ~x;
        sb.push_back(mk(3, 64'h0, 1'b1));
        req = 4'b1000;
        wait_for(0, 20, ok, n);
        n_checks++;
        if (!ok || gnt !== 4'b1000) $display("FAIL to_gnt: ok=%0d gnt=%b, want 1000", ok, gnt);
        else n_pass++;
        wait_for(1, 30, ok, n);
        n_checks++;
        if (!ok || n != 8) $display("FAIL to_latency: ok=%0d cycles=%0d, want 1 8", ok, n);
        else n_pass++;
        req = '0;
        unit_hang = 1'b0;
        @(negedge clk);
        req_a[2*W +: W] = x ^ 64'h1;
        req_b[2*W +: W] = x;
        sb.push_back(mk(2, unit_f(x ^ 64'h1, x), 1'b0));
        req = 4'b0100;
        wait_for(1, 30, ok, n);
        n_checks++;
        if (!ok || n != 5) $display("FAIL to_recover: ok=%0d cycles=%0d, want 1 5", ok, n);
        else n_pass++;
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_stale_done();
        bit ok; int n;
        logic [63:0] a0, a1;
        for (int v = 0; v < 2; v++) begin
            apply_reset();
            unit_stale = (v == 0) ? 3 : 6;
            a0 = {$urandom, $urandom};
            a1 = {$urandom, $urandom};
            req_a[0*W +: W] = a0; req_b[0*W +: W] = ~a0;
            req_a[1*W +: W] = a1; req_b[1*W +: W] = ~a1;
            sb.push_back(mk(0, unit_f(a0, ~a0), 1'b0));
            sb.push_back(mk(1, unit_f(a1, ~a1), 1'b0));
            req = 4'b0011;
            wait_for(1, 30, ok, n);
            n_checks++;
            if (!ok) $display("FAIL stale_first_rsp: variant %0d no response", v);
            else n_pass++;
            req = 4'b0010;
            @(negedge clk);
            wait_for(0, 20, ok, n);
            n_checks++;
            if (!ok || gnt !== 4'b0010) $display("FAIL stale_gnt2: variant %0d gnt=%b, want 0010", v, gnt);
            else n_pass++;
            wait_for(1, 30, ok, n);
            n_checks++;
            if (!ok || n != ((v == 0) ? 4 : 2))
                $display("FAIL stale_latency: variant %0d ok=%0d cycles=%0d, want %0d", v, ok, n, (v == 0) ? 4 : 2);
            else n_pass++;
            req = '0;
            repeat (15) @(negedge clk);
        end
        unit_stale = 0;
    endtask

    task automatic test_reset_mid_wait();
        bit ok; int n; bit bad;
        logic [63:0] y = 64'h0F1E2D3C4B5A6978;
        req_a[1*W +: W] = y; req_b[1*W +: W] = y;
        req = 4'b0010;
        wait_for(0, 20, ok, n);
        n_checks++;
        if (!ok || gnt !== 4'b0010) $display("FAIL rst_gnt: gnt=%b, want 0010", gnt);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({gnt, rsp_valid, rsp_err, busy, prj_start} !== '0 || {rsp_data, prj_a, prj_b} !== '0)
            $display("FAIL rst_mid_outputs: gnt=%b rsp_valid=%b busy=%b prj_a=%h, want 0", gnt, rsp_valid, busy, prj_a);
        else n_pass++;
        reset = 1'b0;
        req   = '0;
        bad   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid !== '0 || busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL rst_late_done: activity after reset, got bad=1, want 0");
        else n_pass++;
        req_a[0*W +: W] = y ^ 64'hFF; req_b[0*W +: W] = y;
        sb.push_back(mk(0, unit_f(y ^ 64'hFF, y), 1'b0));
        req = 4'b1001;
        wait_for(0, 20, ok, n);
        n_checks++;
        if (!ok || gnt !== 4'b0001) $display("FAIL rst_rr_ptr: gnt=%b, want 0001", gnt);
        else n_pass++;
        wait_for(1, 30, ok, n);
        req = '0;
        @(negedge clk);
        req_a[2*W +: W] = ~y; req_b[2*W +: W] = y;
        sb.push_back(mk(2, unit_f(~y, y), 1'b0));
        req = 4'b0100;
        wait_for(1, 30, ok, n);
        n_checks++;
        if (!ok) $display("FAIL rst_fresh_rsp: no response, want one");
        else n_pass++;
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_req_drop();
        bit ok; int n;
        logic [63:0] x = 64'h5555AAAA3333CCCC;
        logic [63:0] y = 64'h0BADBEEF00C0FFEE;
        req_a[2*W +: W] = x; req_b[2*W +: W] = y;
        sb.push_back(mk(2, unit_f(x, y), 1'b0));
        req = 4'b0100;
        wait_for(0, 20, ok, n);
        n_checks++;
        if (!ok || gnt !== 4'b0100) $display("FAIL drop_gnt: gnt=%b, want 0100", gnt);
        else n_pass++;
        req[2] = 1'b0;
        req_a[2*W +: W] = 64'h0;
        wait_for(1, 30, ok, n);
        n_checks++;
        if (!ok || n != 4) $display("FAIL drop_rsp: ok=%0d cycles=%0d, want 1 4", ok, n);
        else n_pass++;
        n_checks++;
        if (prj_a !== x) $display("FAIL drop_prj_a: prj_a=%h, want %h", prj_a, x);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_stale_done();
        test_reset_mid_wait();
        test_req_drop();
        repeat (5) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) $display("FAIL sb_empty: %0d responses outstanding, want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
